gemm_req_receiver: RTL and testbench
====================================

# gemm_req_receiver

Matrix-memory-side receiver for GEMM requests produced by the GEMM functional unit. It buffers incoming request packets (opcode, new-weight flag, rd/rs1/rs2/rs3 matrix selectors) in a small FIFO. For each request it sequences the scratchpad row reads that feed the systolic array: weights from rs2 (only when new_weight=1), inputs from rs1, and partial sums from rs3. It then waits for the array to finish and reports completion with the destination matrix rd.

## Interface
Parameters:
- MAT_W, 4: width of a matrix selector (rd/rs1/rs2/rs3).
- ROWS, 4: rows per matrix, which is the read count per phase.
- ROW_W, 2: row index width, equal to clog2(ROWS).
- DEPTH, 2: request FIFO entries.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  asynchronous, active-high reset (1 = reset asserted). The name is kept per codebase convention.
- req_valid  in  1  request packet present.
- req_ready  out  1  FIFO can accept; equals count<DEPTH.
- req_opcode  in  matrix_mem_t  must be M_GEMM.
- req_new_weight  in  1  reload the array weights from rs2.
- req_rd, req_rs1, req_rs2, req_rs3  in  MAT_W each  matrix selectors.
- sp_rd_en  out  1  scratchpad row-read request.
- sp_rd_mat  out  MAT_W  matrix being read.
- sp_rd_row  out  ROW_W  row being read.
- sp_rd_kind  out  gemm_rd_kind_t  routing tag: WEIGHT=0, INPUT=1, PSUM=2.
- sp_rd_gnt  in  1  read accepted this cycle.
- sa_done  in  1  single-cycle pulse: the array has emitted its last result row.
- done  out  1  single-cycle pulse: request complete.
- done_rd  out  MAT_W  destination selector; valid only while done=1.
- busy  out  1  FSM not IDLE, or FIFO non-empty.
- bad_op  out  1  single-cycle pulse: a non-GEMM packet was dropped.

## Operation
- Accept a packet on req_valid & req_ready.
  - Opcode ≠ M_GEMM: the packet is not enqueued, and bad_op pulses in the following cycle.
- FIFO: DEPTH entries, registered count, circular read/write pointers that wrap at DEPTH.
  - req_ready is derived from the registered count only. When full, no packet is accepted in the same cycle as a pop.
- FSM states: IDLE, WLOAD, INPUT, PSUM, WAIT.
  - IDLE: when the FIFO is non-empty, pop the head into working registers. Go to WLOAD if new_weight=1, else INPUT.
  - WLOAD, INPUT, PSUM: drive sp_rd_en=1 with mat = rs2, rs1, rs3 respectively, the matching kind, and row = row counter.
    - On sp_rd_gnt, increment the row counter.
    - On a gnt at row ROWS-1, clear the counter and advance: WLOAD→INPUT→PSUM→WAIT.
    - Without gnt, hold all request outputs stable.
  - WAIT: sp_rd_en=0. On sa_done, pulse done with done_rd = working rd, then go to IDLE.
- sa_done in any state other than WAIT is ignored.
- When new_weight=0, the array keeps its previous weights (zeros after array reset). No check is made here.
- No operand hazard checking; the upstream scoreboard owns it.

## Timing
- Reset values: req_ready=0 while nRST=1, and 1 in the first cycle after deassertion. sp_rd_en=0, sp_rd_mat=0, sp_rd_row=0, sp_rd_kind=WEIGHT, done=0, done_rd=0, busy=0, bad_op=0. FIFO is empty and the FSM is in IDLE.
- Reset mid-operation: the FIFO and working request are discarded and no done pulse is produced.
- Acceptance at edge N into an empty FIFO in IDLE: the pop occurs at edge N+1, and sp_rd_en is first high in cycle N+1→N+2.
- Full-rate read throughput with constant gnt:
  - new_weight=1: 3×ROWS consecutive read cycles.
  - new_weight=0: 2×ROWS consecutive read cycles.
- sa_done sampled at edge M: done is high for the cycle after M, and the FSM is in IDLE after M.
  - The next pop happens no earlier than edge M+1.
- bad_op and done are registered, single-cycle pulses.

## Structure
- The shared datapath package holds:
  - gemm_rd_kind_t (2-bit enum WEIGHT/INPUT/PSUM/RSVD);
  - the request struct gemm_req_t {new_weight, rd, rs1, rs2, rs3};
  - the FSM state enum.
- matrix_mem_t and M_GEMM come from the existing package.
- One sub-module: gemm_req_fifo, a parameterized DEPTH-entry FIFO of gemm_req_t with push/pop/full/empty/count.

## Test plan
- After reset with no stimulus: every output holds its reset value; req_ready=1 in the first post-reset cycle.
- Packet {M_GEMM, nw=1, rd=3, rs1=1, rs2=2, rs3=4}, gnt=1 → 12 consecutive reads:
  - mat 2 rows 0-3 WEIGHT, then mat 1 rows 0-3 INPUT, then mat 4 rows 0-3 PSUM;
  - then sa_done → done=1 with done_rd=3 for one cycle.
- nw=0, gnt toggling 1,0,1,0 → exactly 8 reads (INPUT then PSUM); row advances only on gnt, and mat/row/kind stay stable across gnt=0.
- Three back-to-back packets while the first is executing → the third sees req_ready=0 until the first pop; all complete in order with done_rd matching each request.
- Non-GEMM opcode with req_valid=1 → bad_op pulses once, FIFO count unchanged, no reads issued.
- nRST asserted during the INPUT phase → outputs reset immediately, FIFO empty, and sa_done after release produces no done pulse.

Source files
------------

// File: rtl/gemm_req_receiver_pkg.sv
// Shared datapath types for the GEMM request receiver.
//   matrix_mem_t   : matrix-memory opcode (M_GEMM is the only one accepted here)
//   gemm_rd_kind_t : routing tag on scratchpad reads (WEIGHT/INPUT/PSUM/RSVD)
//   gemm_req_t     : buffered request {new_weight, rd, rs1, rs2, rs3}
//   gemm_state_t   : receiver sequencing states
package gemm_req_receiver_pkg;

    typedef enum logic [1:0] {
        M_LOAD  = 2'd0,
        M_STORE = 2'd1,
        M_GEMM  = 2'd2,
        M_CONV  = 2'd3
    } matrix_mem_t;

    // Selector width carried by the buffered request.
    localparam int unsigned GEMM_MAT_W = 4;

    typedef enum logic [1:0] {
        WEIGHT = 2'd0,
        INPUT  = 2'd1,
        PSUM   = 2'd2,
        RSVD   = 2'd3
    } gemm_rd_kind_t;

    typedef struct packed {
        logic                  new_weight;
        logic [GEMM_MAT_W-1:0] rd;
        logic [GEMM_MAT_W-1:0] rs1;
        logic [GEMM_MAT_W-1:0] rs2;
        logic [GEMM_MAT_W-1:0] rs3;
    } gemm_req_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WLOAD = 3'd1,
        S_INPUT = 3'd2,
        S_PSUM  = 3'd3,
        S_WAIT  = 3'd4
    } gemm_state_t;

endpackage

// File: rtl/gemm_req_receiver_fifo.sv
// gemm_req_fifo: DEPTH-entry FIFO of gemm_req_t with registered count and
// circular read/write pointers.
//   clk, rst          : clock, asynchronous active-high reset
//   push, push_data   : enqueue (ignored when full)
//   pop, pop_data     : dequeue (ignored when empty); pop_data shows the head
//   full, empty, count: occupancy status
module gemm_req_fifo
    import gemm_req_receiver_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  gemm_req_t        push_data,
    input  logic             pop,
    output gemm_req_t        pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    gemm_req_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gemm_req_receiver.sv
// gemm_req_receiver: buffers GEMM request packets and sequences the scratchpad
// row reads feeding the systolic array (weights from rs2 when new_weight=1,
// inputs from rs1, partial sums from rs3), then waits for sa_done and reports
// completion with the destination rd.
//   CLK, nRST            : clock, asynchronous active-high reset
//   req_*                : request packet handshake and fields
//   sp_rd_*              : scratchpad row-read request / grant
//   sa_done              : array finished the current request
//   done, done_rd        : completion pulse and destination selector
//   busy                 : work in flight or queued
//   bad_op               : pulse when a non-GEMM packet is dropped
module gemm_req_receiver
    import gemm_req_receiver_pkg::*;
#(
    parameter int unsigned MAT_W = 4,
    parameter int unsigned ROWS  = 4,
    parameter int unsigned ROW_W = 2,
    parameter int unsigned DEPTH = 2
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              req_valid,
    output logic              req_ready,
    input  matrix_mem_t       req_opcode,
    input  logic              req_new_weight,
    input  logic [MAT_W-1:0]  req_rd,
    input  logic [MAT_W-1:0]  req_rs1,
    input  logic [MAT_W-1:0]  req_rs2,
    input  logic [MAT_W-1:0]  req_rs3,
    output logic              sp_rd_en,
    output logic [MAT_W-1:0]  sp_rd_mat,
    output logic [ROW_W-1:0]  sp_rd_row,
    output gemm_rd_kind_t     sp_rd_kind,
    input  logic              sp_rd_gnt,
    input  logic              sa_done,
    output logic              done,
    output logic [MAT_W-1:0]  done_rd,
    output logic              busy,
    output logic              bad_op
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    gemm_state_t      state;
    gemm_state_t      state_next;
    gemm_req_t        push_data;
    gemm_req_t        pop_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             accept;
    logic             push;
    logic             pop;
    logic             reading;
    logic             row_last;
    logic             wait_done;
    logic [ROW_W-1:0] row_cnt;
    logic [MAT_W-1:0] cur_rd;
    logic [MAT_W-1:0] cur_rs1;
    logic [MAT_W-1:0] cur_rs2;
    logic [MAT_W-1:0] cur_rs3;

    // Ready is gated by reset directly so it reads 0 during reset and 1 in
    // the first cycle after release, without waiting for a clock edge.
    assign req_ready = !nRST && !fifo_full;
    assign accept    = req_valid && req_ready;
    assign push      = accept && (req_opcode == M_GEMM);
    assign pop       = (state == S_IDLE) && !fifo_empty;
    assign busy      = (state != S_IDLE) || (fifo_count != '0);

    assign push_data = '{
        new_weight: req_new_weight,
        rd:         req_rd,
        rs1:        req_rs1,
        rs2:        req_rs2,
        rs3:        req_rs3
    };

    gemm_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst       (nRST),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign reading   = (state == S_WLOAD) || (state == S_INPUT) || (state == S_PSUM);
    assign row_last  = (row_cnt == ROW_W'(ROWS - 1));
    assign wait_done = (state == S_WAIT) && sa_done;

    // State register
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_next = pop_data.new_weight ? S_WLOAD : S_INPUT;
                end
            end
            S_WLOAD: if (sp_rd_gnt && row_last) state_next = S_INPUT;
            S_INPUT: if (sp_rd_gnt && row_last) state_next = S_PSUM;
            S_PSUM:  if (sp_rd_gnt && row_last) state_next = S_WAIT;
            S_WAIT:  if (sa_done)               state_next = S_IDLE;
            default:                            state_next = S_IDLE;
        endcase
    end

    // Read-request outputs; mat/kind/row depend only on registered state,
    // so they stay stable across cycles without a grant.
    always_comb begin
        sp_rd_en   = 1'b0;
        sp_rd_mat  = '0;
        sp_rd_kind = WEIGHT;
        case (state)
            S_WLOAD: begin
                sp_rd_en   = 1'b1;
                sp_rd_mat  = cur_rs2;
                sp_rd_kind = WEIGHT;
            end
            S_INPUT: begin
                sp_rd_en   = 1'b1;
                sp_rd_mat  = cur_rs1;
                sp_rd_kind = INPUT;
            end
            S_PSUM: begin
                sp_rd_en   = 1'b1;
                sp_rd_mat  = cur_rs3;
                sp_rd_kind = PSUM;
            end
            default: ;
        endcase
    end

    assign sp_rd_row = row_cnt;

    // Working request, row counter and registered pulses
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            cur_rd  <= '0;
            cur_rs1 <= '0;
            cur_rs2 <= '0;
            cur_rs3 <= '0;
            row_cnt <= '0;
            done    <= 1'b0;
            done_rd <= '0;
            bad_op  <= 1'b0;
        end else begin
            if (pop) begin
                cur_rd  <= pop_data.rd;
                cur_rs1 <= pop_data.rs1;
                cur_rs2 <= pop_data.rs2;
                cur_rs3 <= pop_data.rs3;
            end
            if (reading && sp_rd_gnt) begin
                row_cnt <= row_last ? '0 : row_cnt + 1'b1;
            end
            done    <= wait_done;
            done_rd <= wait_done ? cur_rd : '0;
            bad_op  <= accept && (req_opcode != M_GEMM);
        end
    end

endmodule

// File: tb/tb_gemm_req_receiver.sv
`timescale 1ns/1ps
module tb_gemm_req_receiver;
    import gemm_req_receiver_pkg::*;

    localparam int unsigned MAT_W = 4;
    localparam int unsigned ROWS  = 4;
    localparam int unsigned ROW_W = 2;
    localparam int unsigned DEPTH = 2;

    logic              CLK = 1'b0;
    logic              nRST = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    matrix_mem_t       req_opcode = M_GEMM;
    logic              req_new_weight = 1'b0;
    logic [MAT_W-1:0]  req_rd = '0, req_rs1 = '0, req_rs2 = '0, req_rs3 = '0;
    logic              sp_rd_en;
    logic [MAT_W-1:0]  sp_rd_mat;
    logic [ROW_W-1:0]  sp_rd_row;
    gemm_rd_kind_t     sp_rd_kind;
    logic              sp_rd_gnt = 1'b0;
    logic              sa_done = 1'b0;
    logic              done;
    logic [MAT_W-1:0]  done_rd;
    logic              busy;
    logic              bad_op;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 CLK = ~CLK;

    gemm_req_receiver #(
        .MAT_W (MAT_W),
        .ROWS  (ROWS),
        .ROW_W (ROW_W),
        .DEPTH (DEPTH)
    ) dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_opcode     (req_opcode),
        .req_new_weight (req_new_weight),
        .req_rd         (req_rd),
        .req_rs1        (req_rs1),
        .req_rs2        (req_rs2),
        .req_rs3        (req_rs3),
        .sp_rd_en       (sp_rd_en),
        .sp_rd_mat      (sp_rd_mat),
        .sp_rd_row      (sp_rd_row),
        .sp_rd_kind     (sp_rd_kind),
        .sp_rd_gnt      (sp_rd_gnt),
        .sa_done        (sa_done),
        .done           (done),
        .done_rd        (done_rd),
        .busy           (busy),
        .bad_op         (bad_op)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A request becomes a list of scratchpad reads; the model walks that list
    // one grant at a time, then waits for sa_done.
    typedef struct {
        logic [MAT_W-1:0] rd, rs1, rs2, rs3;
        logic             nw;
    } job_t;
    typedef struct {
        logic [MAT_W-1:0] mat;
        logic [ROW_W-1:0] row;
        logic [1:0]       kind;
    } rdop_t;

    job_t             jq[$];
    rdop_t            rl[$];
    int               m_phase;   // 0 no job, 1 reading, 2 awaiting sa_done
    logic [MAT_W-1:0] m_rd;
    logic             m_done, m_bad;
    logic [MAT_W-1:0] m_done_rd;

    always @(posedge CLK or posedge nRST) begin
        bit   acc;
        job_t j;
        if (nRST) begin
            jq.delete();
            rl.delete();
            m_phase = 0;
            m_rd = '0;
            m_done = 1'b0;
            m_bad = 1'b0;
            m_done_rd = '0;
        end else begin
            acc = req_valid && (jq.size() < DEPTH);
            m_done = 1'b0;
            m_bad = 1'b0;
            m_done_rd = '0;
            if (m_phase == 1) begin
                if (sp_rd_gnt) begin
                    void'(rl.pop_front());
                    if (rl.size() == 0) m_phase = 2;
                end
            end else if (m_phase == 2) begin
                if (sa_done) begin
                    m_done = 1'b1;
                    m_done_rd = m_rd;
                    m_phase = 0;
                end
            end else if (jq.size() > 0) begin
                j = jq.pop_front();
                m_rd = j.rd;
                if (j.nw) for (int r = 0; r < ROWS; r++) rl.push_back('{j.rs2, ROW_W'(r), 2'd0});
                for (int r = 0; r < ROWS; r++) rl.push_back('{j.rs1, ROW_W'(r), 2'd1});
                for (int r = 0; r < ROWS; r++) rl.push_back('{j.rs3, ROW_W'(r), 2'd2});
                m_phase = 1;
            end
            if (acc) begin
                if (req_opcode == M_GEMM) begin
                    j.rd = req_rd; j.rs1 = req_rs1; j.rs2 = req_rs2; j.rs3 = req_rs3;
                    j.nw = req_new_weight;
                    jq.push_back(j);
                end else begin
                    m_bad = 1'b1;
                end
            end
        end
    end

    // Compare process: every cycle, DUT outputs against the model.
    always @(negedge CLK) begin
        logic             e_en;
        logic [MAT_W-1:0] e_mat;
        logic [ROW_W-1:0] e_row;
        logic [1:0]       e_kind;
        e_en = (m_phase == 1) && (rl.size() > 0);
        e_mat = e_en ? rl[0].mat : '0;
        e_row = e_en ? rl[0].row : '0;
        e_kind = e_en ? rl[0].kind : 2'd0;
        chk("m_req_ready", 32'(req_ready), 32'(!nRST && (jq.size() < DEPTH)));
        chk("m_sp_rd_en", 32'(sp_rd_en), 32'(e_en));
        chk("m_sp_rd_mat", 32'(sp_rd_mat), 32'(e_mat));
        chk("m_sp_rd_row", 32'(sp_rd_row), 32'(e_row));
        chk("m_sp_rd_kind", 32'(sp_rd_kind), 32'(e_kind));
        chk("m_done", 32'(done), 32'(m_done));
        chk("m_done_rd", 32'(done_rd), 32'(m_done_rd));
        chk("m_busy", 32'(busy), 32'((m_phase != 0) || (jq.size() > 0)));
        chk("m_bad_op", 32'(bad_op), 32'(m_bad));
    end

    logic [MAT_W-1:0] done_log[$];
    always @(negedge CLK) if (done === 1'b1) done_log.push_back(done_rd);

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(negedge CLK);
        #1;
    endtask

    task automatic send(input matrix_mem_t op, input logic nw,
                        input logic [MAT_W-1:0] rd, rs1, rs2, rs3);
        int unsigned w = 0;
        while (!req_ready && w < 100) begin
            cyc();
            w++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: req_ready got 0 required 1 at %0t", $time);
        end
        req_valid = 1'b1; req_opcode = op; req_new_weight = nw;
        req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_rs3 = rs3;
        cyc();
        req_valid = 1'b0;
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int unsigned nrd;
        logic        g;
        int unsigned w;

        // reset values
        repeat (3) cyc();
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_en", 32'(sp_rd_en), 32'd0);
        chk("rst_mat", 32'(sp_rd_mat), 32'd0);
        chk("rst_row", 32'(sp_rd_row), 32'd0);
        chk("rst_kind", 32'(sp_rd_kind), 32'(WEIGHT));
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_done_rd", 32'(done_rd), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bad_op", 32'(bad_op), 32'd0);
        nRST = 1'b0;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        cyc();

        // Test 1: nw=1, constant grant -> 12 reads then done
        sp_rd_gnt = 1'b1;
        send(M_GEMM, 1'b1, 4'd3, 4'd1, 4'd2, 4'd4);
        chk("t1_idle_before_pop", 32'(sp_rd_en), 32'd0);
        cyc();
        for (int i = 0; i < 12; i++) begin
            chk("t1_en", 32'(sp_rd_en), 32'd1);
            chk("t1_mat", 32'(sp_rd_mat), (i < 4) ? 32'd2 : (i < 8) ? 32'd1 : 32'd4);
            chk("t1_row", 32'(sp_rd_row), 32'(i % 4));
            chk("t1_kind", 32'(sp_rd_kind), 32'(i / 4));
            cyc();
        end
        chk("t1_wait_en", 32'(sp_rd_en), 32'd0);
        chk("t1_wait_busy", 32'(busy), 32'd1);
        sa_done = 1'b1;
        cyc();
        sa_done = 1'b0;
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_done_rd", 32'(done_rd), 32'd3);
        cyc();
        chk("t1_done_single", 32'(done), 32'd0);

        // Test 2: nw=0, grant toggling -> 8 reads, stable across gnt=0
        send(M_GEMM, 1'b0, 4'd5, 4'd6, 4'd7, 4'd8);
        nrd = 0;
        g = 1'b1;
        for (int c = 0; c < 40 && nrd < 8; c++) begin
            sp_rd_gnt = g;
            if (sp_rd_en) begin
                chk("t2_mat", 32'(sp_rd_mat), (nrd < 4) ? 32'd6 : 32'd8);
                chk("t2_row", 32'(sp_rd_row), 32'(nrd % 4));
                chk("t2_kind", 32'(sp_rd_kind), (nrd < 4) ? 32'(INPUT) : 32'(PSUM));
                if (g) nrd++;
            end
            cyc();
            g = !g;
        end
        chk("t2_reads", 32'(nrd), 32'd8);
        chk("t2_en_after", 32'(sp_rd_en), 32'd0);
        sa_done = 1'b1;
        cyc();
        sa_done = 1'b0;
        chk("t2_done_rd", 32'(done_rd), 32'd5);
        sp_rd_gnt = 1'b1;
        cyc();

        // Test 3: back-to-back packets fill the FIFO; completion in order
        done_log.delete();
        send(M_GEMM, 1'b1, 4'd1, 4'd2, 4'd3, 4'd4);
        cyc();
        send(M_GEMM, 1'b0, 4'd2, 4'd5, 4'd6, 4'd7);
        send(M_GEMM, 1'b1, 4'd3, 4'd8, 4'd9, 4'd10);
        chk("t3_full_ready", 32'(req_ready), 32'd0);
        sa_done = 1'b1;
        send(M_GEMM, 1'b0, 4'd4, 4'd11, 4'd12, 4'd13);
        w = 0;
        while (done_log.size() < 4 && w < 200) begin
            cyc();
            w++;
        end
        sa_done = 1'b0;
        chk("t3_done_count", 32'(done_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < done_log.size()) chk("t3_done_order", 32'(done_log[i]), 32'(i + 1));
        end
        cyc();

        // Test 4: non-GEMM opcode dropped
        send(M_LOAD, 1'b1, 4'd9, 4'd9, 4'd9, 4'd9);
        chk("t4_bad_op", 32'(bad_op), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_en", 32'(sp_rd_en), 32'd0);
        cyc();
        chk("t4_bad_op_single", 32'(bad_op), 32'd0);
        chk("t4_en_after", 32'(sp_rd_en), 32'd0);

        // Test 5: reset during the INPUT phase
        sp_rd_gnt = 1'b0;
        send(M_GEMM, 1'b0, 4'd9, 4'd2, 4'd3, 4'd4);
        cyc();
        chk("t5_in_input", 32'(sp_rd_kind), 32'(INPUT));
        chk("t5_en", 32'(sp_rd_en), 32'd1);
        nRST = 1'b1;
        #1;
        chk("t5_rst_en", 32'(sp_rd_en), 32'd0);
        chk("t5_rst_mat", 32'(sp_rd_mat), 32'd0);
        chk("t5_rst_kind", 32'(sp_rd_kind), 32'(WEIGHT));
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_ready", 32'(req_ready), 32'd0);
        cyc();
        cyc();
        nRST = 1'b0;
        #1;
        chk("t5_ready_release", 32'(req_ready), 32'd1);
        sa_done = 1'b1;
        cyc();
        sa_done = 1'b0;
        chk("t5_no_done", 32'(done), 32'd0);
        cyc();
        chk("t5_no_done2", 32'(done), 32'd0);
        chk("t5_idle", 32'(busy), 32'd0);

        // Randomized traffic, checked cycle by cycle against the model
        for (int c = 0; c < 3000; c++) begin
            req_valid      = ($urandom_range(0, 2) == 0);
            req_opcode     = ($urandom_range(0, 9) == 0) ? matrix_mem_t'($urandom_range(0, 3)) : M_GEMM;
            req_new_weight = 1'($urandom);
            req_rd         = 4'($urandom);
            req_rs1        = 4'($urandom);
            req_rs2        = 4'($urandom);
            req_rs3        = 4'($urandom);
            sp_rd_gnt      = ($urandom_range(0, 3) != 0);
            sa_done        = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 999) == 0) nRST = 1'b1;
            cyc();
            nRST = 1'b0;
        end
        req_valid = 1'b0;
        sa_done = 1'b0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
